// File: rtl/conn_setup_sequencer.sv
// Connection-setup command sequencer: turns one open/close descriptor into the ordered frame stream for rpc.
// Optional per-type completion counters are built when CONN_SETUP_STATS_EN is defined.

package conn_setup_pkg;
  typedef enum logic [2:0] {
    SETUP_CONN_ID        = 3'd0,
    SETUP_OPEN           = 3'd1,
    SETUP_DEST_IPV4      = 3'd2,
    SETUP_DEST_PORT      = 3'd3,
    SETUP_CLIENT_FLOW_ID = 3'd4,
    SETUP_QP_FIELDS      = 3'd5,
    SETUP_ENABLE         = 3'd6
  } conn_setup_cmd_e;

  typedef struct packed {
    conn_setup_cmd_e cmd;
    logic [63:0]     data;
  } ConnSetupFrame;

  typedef logic [7:0] ConnSetupStatus;
endpackage

// state  | meaning
// IDLE   | ready for a descriptor
// SEND   | one frame strobe on the output this cycle
// GAP    | idle spacing between frames
// SETTLE | waiting for rpc to settle after the Enable frame
// RESP   | one-cycle completion pulse
module conn_setup_sequencer
  import conn_setup_pkg::*;
#(
  parameter int NIC_ID        = 0,
  parameter int CONN_ID_WIDTH = 16,
  parameter int FLOW_ID_WIDTH = 8,
  parameter int FRAME_GAP     = 0,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_open,
  input  logic [CONN_ID_WIDTH-1:0] req_conn_id,
  input  logic [31:0]              req_dest_ip,
  input  logic [15:0]              req_dest_port,
  input  logic [FLOW_ID_WIDTH-1:0] req_client_flow_id,
  input  logic [15:0]              req_remote_qp_num,
  input  logic [15:0]              req_p_key,
  input  logic [31:0]              req_q_key,
  output logic                     conn_setup_en_out,
  output ConnSetupFrame            conn_setup_frame_out,
  input  ConnSetupStatus           conn_setup_status_in,
  input  logic                     rpc_error_in,
  output logic                     resp_valid,
  output logic                     resp_error,
  output ConnSetupStatus           resp_status,
  output logic                     busy
`ifdef CONN_SETUP_STATS_EN
  ,
  output logic [31:0]              stat_opens,
  output logic [31:0]              stat_closes,
  output logic [31:0]              stat_errors
`endif
);

  if (SETTLE_CYCLES < 1 || FRAME_GAP < 0 || NIC_ID < 0 ||
      CONN_ID_WIDTH > 64 || FLOW_ID_WIDTH > 64) begin : g_param_check
    $error("conn_setup_sequencer: illegal parameter value");
  end

  localparam int GAP_W = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;
  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [2:0] LAST_OPEN  = 3'd6;
  localparam logic [2:0] LAST_CLOSE = 3'd2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SEND   = 3'd1,
    S_GAP    = 3'd2,
    S_SETTLE = 3'd3,
    S_RESP   = 3'd4
  } state_e;

  state_e                   r_state, w_state_nxt;
  logic [2:0]               r_idx, w_idx_nxt, w_next_idx, w_last_idx;
  logic [GAP_W-1:0]         r_gap_cnt, w_gap_nxt;
  logic [SET_W-1:0]         r_settle_cnt, w_settle_nxt;

  logic                     r_open;
  logic [CONN_ID_WIDTH-1:0] r_conn_id;
  logic [31:0]              r_dest_ip;
  logic [15:0]              r_dest_port;
  logic [FLOW_ID_WIDTH-1:0] r_client_flow_id;
  logic [15:0]              r_remote_qp_num;
  logic [15:0]              r_p_key;
  logic [31:0]              r_q_key;
  logic                     r_err_base;

  logic                     r_en, w_en_nxt;
  ConnSetupFrame            r_frame, w_frame_nxt, w_cand_frame;
  logic                     r_resp_valid, w_resp_valid_nxt;
  logic                     r_resp_error;
  ConnSetupStatus           r_resp_status;
  logic                     w_accept, w_capture;

  assign w_last_idx = r_open ? LAST_OPEN : LAST_CLOSE;
  // In GAP the index was already advanced when leaving SEND.
  assign w_next_idx = (r_state == S_GAP) ? r_idx : r_idx + 3'd1;

  always_comb begin : cand_frame
    w_cand_frame = '0;
    if (r_open) begin
      w_cand_frame.cmd = conn_setup_cmd_e'(w_next_idx);
    end else begin
      case (w_next_idx)
        3'd0:    w_cand_frame.cmd = SETUP_CONN_ID;
        3'd1:    w_cand_frame.cmd = SETUP_OPEN;
        default: w_cand_frame.cmd = SETUP_ENABLE;
      endcase
    end
    case (w_cand_frame.cmd)
      SETUP_CONN_ID:        w_cand_frame.data = 64'(r_conn_id);
      SETUP_OPEN:           w_cand_frame.data = {63'b0, r_open};
      SETUP_DEST_IPV4:      w_cand_frame.data = {32'b0, r_dest_ip};
      SETUP_DEST_PORT:      w_cand_frame.data = {48'b0, r_dest_port};
      SETUP_CLIENT_FLOW_ID: w_cand_frame.data = 64'(r_client_flow_id);
      SETUP_QP_FIELDS:      w_cand_frame.data = {r_remote_qp_num, r_p_key, r_q_key};
      default:              w_cand_frame.data = 64'b0;
    endcase
  end

  always_comb begin : fsm_next
    w_state_nxt      = r_state;
    w_idx_nxt        = r_idx;
    w_gap_nxt        = r_gap_cnt;
    w_settle_nxt     = r_settle_cnt;
    w_en_nxt         = 1'b0;
    w_frame_nxt      = '0;
    w_resp_valid_nxt = 1'b0;
    w_accept         = 1'b0;
    w_capture        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_accept         = 1'b1;
          w_state_nxt      = S_SEND;
          w_idx_nxt        = 3'd0;
          w_en_nxt         = 1'b1;
          w_frame_nxt.cmd  = SETUP_CONN_ID;
          w_frame_nxt.data = 64'(req_conn_id);
        end
      end
      S_SEND: begin
        if (r_idx > w_last_idx) begin
          w_state_nxt = S_IDLE;
        end else if (r_idx == w_last_idx) begin
          w_state_nxt  = S_SETTLE;
          w_settle_nxt = SET_W'(SETTLE_CYCLES - 1);
        end else if (FRAME_GAP > 0) begin
          w_state_nxt = S_GAP;
          w_idx_nxt   = r_idx + 3'd1;
          w_gap_nxt   = GAP_W'(FRAME_GAP - 1);
        end else begin
          w_idx_nxt   = r_idx + 3'd1;
          w_en_nxt    = 1'b1;
          w_frame_nxt = w_cand_frame;
        end
      end
      S_GAP: begin
        if (r_idx > w_last_idx) begin
          w_state_nxt = S_IDLE;
        end else if (r_gap_cnt == '0) begin
          w_state_nxt = S_SEND;
          w_en_nxt    = 1'b1;
          w_frame_nxt = w_cand_frame;
        end else begin
          w_gap_nxt = r_gap_cnt - 1'b1;
        end
      end
      S_SETTLE: begin
        if (r_settle_cnt == '0) begin
          w_capture        = 1'b1;
          w_state_nxt      = S_RESP;
          w_resp_valid_nxt = 1'b1;
        end else begin
          w_settle_nxt = r_settle_cnt - 1'b1;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin : state_reg
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin : datapath_reg
    if (!reset) begin
      r_idx            <= '0;
      r_gap_cnt        <= '0;
      r_settle_cnt     <= '0;
      r_open           <= 1'b0;
      r_conn_id        <= '0;
      r_dest_ip        <= '0;
      r_dest_port      <= '0;
      r_client_flow_id <= '0;
      r_remote_qp_num  <= '0;
      r_p_key          <= '0;
      r_q_key          <= '0;
      r_err_base       <= 1'b0;
      r_en             <= 1'b0;
      r_frame          <= '0;
      r_resp_valid     <= 1'b0;
      r_resp_error     <= 1'b0;
      r_resp_status    <= '0;
    end else begin
      r_idx        <= w_idx_nxt;
      r_gap_cnt    <= w_gap_nxt;
      r_settle_cnt <= w_settle_nxt;
      r_en         <= w_en_nxt;
      r_frame      <= w_frame_nxt;
      r_resp_valid <= w_resp_valid_nxt;
      if (w_accept) begin
        r_open           <= req_open;
        r_conn_id        <= req_conn_id;
        r_dest_ip        <= req_dest_ip;
        r_dest_port      <= req_dest_port;
        r_client_flow_id <= req_client_flow_id;
        r_remote_qp_num  <= req_remote_qp_num;
        r_p_key          <= req_p_key;
        r_q_key          <= req_q_key;
        r_err_base       <= rpc_error_in;
      end
      // An rpc error already present at accept belongs to an earlier request.
      if (w_capture) begin
        r_resp_status <= conn_setup_status_in;
        r_resp_error  <= rpc_error_in & ~r_err_base;
      end
    end
  end

  assign req_ready            = (r_state == S_IDLE);
  assign busy                 = (r_state != S_IDLE);
  assign conn_setup_en_out    = r_en;
  assign conn_setup_frame_out = r_frame;
  assign resp_valid           = r_resp_valid;
  assign resp_error           = r_resp_error;
  assign resp_status          = r_resp_status;

`ifdef CONN_SETUP_STATS_EN
  logic [31:0] r_stat_opens, r_stat_closes, r_stat_errors;

  always_ff @(posedge clk) begin : stats_reg
    if (!reset) begin
      r_stat_opens  <= '0;
      r_stat_closes <= '0;
      r_stat_errors <= '0;
    end else if (r_resp_valid) begin
      if (r_open && (r_stat_opens != '1))   r_stat_opens  <= r_stat_opens + 32'd1;
      if (!r_open && (r_stat_closes != '1)) r_stat_closes <= r_stat_closes + 32'd1;
      if (r_resp_error && (r_stat_errors != '1)) r_stat_errors <= r_stat_errors + 32'd1;
    end
  end

  assign stat_opens  = r_stat_opens;
  assign stat_closes = r_stat_closes;
  assign stat_errors = r_stat_errors;
`endif

endmodule
